// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_bitstream_loader
// Brief    : Serializes a byte-wide bitstream onto a configuration DFF chain,
//            gating the chain's shift so it only advances on real bits.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 200,
    parameter int CNT_W     = 16
) (
    input  logic        prog_clk,
    input  logic        prog_reset_n,
    input  logic        start,
    input  logic [7:0]  cfg_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    output logic        ccff_head,
    output logic        chain_shift_en,
    input  logic        ccff_tail,
    output logic        busy,
    output logic        done,
    output logic [15:0] tail_ones
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_chain_len = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    state_t           r_state;
    logic [7:0]       r_shreg;
    logic             r_have_byte;
    logic [2:0]       r_bit_idx;
    logic [CNT_W-1:0] r_remaining;
    logic [15:0]      r_tail_ones;
    logic             r_done;

    logic w_load;
    logic w_shift;
    logic w_ready;
    logic w_accept;
    logic w_terminal;

    assign w_load     = (r_state == S_LOAD);
    assign w_shift    = w_load && r_have_byte;
    // Ready during the last bit of a byte so consecutive bytes stream with no bubble.
    assign w_ready    = w_load && (r_remaining != '0) &&
                        (!r_have_byte || ((r_bit_idx == 3'd7) && (r_remaining > c_one)));
    assign w_accept   = cfg_valid && w_ready;
    assign w_terminal = w_shift && (r_remaining == c_one);

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state     <= S_IDLE;
            r_shreg     <= 8'h00;
            r_have_byte <= 1'b0;
            r_bit_idx   <= 3'd0;
            r_remaining <= '0;
            r_tail_ones <= 16'h0000;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_LOAD;
                        r_remaining <= c_chain_len;
                        r_tail_ones <= 16'h0000;
                        r_done      <= 1'b0;
                        r_have_byte <= 1'b0;
                        r_bit_idx   <= 3'd0;
                        r_shreg     <= 8'h00;
                    end
                end
                S_LOAD: begin
                    if (w_shift) begin
                        r_shreg     <= {r_shreg[6:0], 1'b0};
                        r_bit_idx   <= r_bit_idx + 3'd1;
                        r_remaining <= r_remaining - c_one;
                        if (ccff_tail && (r_tail_ones != 16'hFFFF)) begin
                            r_tail_ones <= r_tail_ones + 16'd1;
                        end
                        if (r_bit_idx == 3'd7) begin
                            r_have_byte <= 1'b0;
                        end
                    end
                    // A newly accepted byte overrides the shift of the one just finishing.
                    if (w_accept) begin
                        r_shreg     <= cfg_data;
                        r_have_byte <= 1'b1;
                        r_bit_idx   <= 3'd0;
                    end
                    if (w_terminal) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_have_byte <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready      = w_ready;
    assign ccff_head      = w_load && r_shreg[7];
    assign chain_shift_en = w_shift;
    assign busy           = w_load;
    assign done           = r_done;
    assign tail_ones      = r_tail_ones;

endmodule
`default_nettype wire

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Upstream feeder of the configuration-chain memories (DFF shift chains clocked by prog_clk, ccff_head to ccff_tail).
- Accepts the bitstream as bytes over a valid/ready interface and serializes it onto ccff_head, one bit per shift cycle.
- Drives a shift enable for the chain's prog_clk gate, so the chain only advances when a real bit is presented.
- Counts exactly CHAIN_LEN shifts, then reports done, plus a popcount of the old contents shifted out of ccff_tail.

Parameters:
- CHAIN_LEN, 200, total configuration bits in the chain (>=1).
- CNT_W, 16, width of the remaining-bit counter; CHAIN_LEN must be < 2^CNT_W.

Ports:
- prog_clk  in  1  configuration clock
- prog_reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a load session
- cfg_data  in  8  bitstream byte, sent MSB first
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader accepts cfg_data this cycle
- ccff_head  out  1  serial bit into the chain head
- chain_shift_en  out  1  enable for the chain's prog_clk gate; the chain captures ccff_head on edges where this is 1
- ccff_tail  in  1  serial bit from the chain tail
- busy  out  1  session in progress
- done  out  1  CHAIN_LEN bits shifted; held until next start
- tail_ones  out  16  count of 1s observed on ccff_tail during shift cycles, saturating

Behaviour:
- Clock and reset: one clock (prog_clk); reset is asynchronous and active-low (prog_reset_n).
- Reset values:
  - State returns to IDLE.
  - cfg_ready=0, chain_shift_en=0, ccff_head=0, busy=0, done=0, tail_ones=0.
  - Byte shift register and have_byte flag cleared.
  - Chain contents are not reset and are undefined.
- States: IDLE, LOAD, DONE.
  - IDLE/DONE: start -> LOAD. On entry: remaining=CHAIN_LEN, tail_ones=0, done=0, have_byte=0.
  - LOAD: start is ignored.
- Byte capture:
  - A byte is accepted on a cycle with cfg_valid && cfg_ready; it is loaded into an 8-bit shift register with have_byte=1 and bit_idx=0.
- Outputs in LOAD:
  - ccff_head = shreg[7] (a registered bit, not combinational from cfg_data).
  - chain_shift_en = LOAD && have_byte.
- Shift cycle (chain_shift_en=1):
  - shreg shifts left and bit_idx increments.
  - remaining decrements.
  - If ccff_tail=1, tail_ones increments; it saturates at 0xFFFF.
- cfg_ready = LOAD && remaining>0 && (!have_byte || (bit_idx==7 && remaining>1)).
  - This lookahead lets the next byte load on the cycle its predecessor's last bit shifts, so back-to-back bytes give 1 bit/cycle with no bubble.
- Last bit of a byte shifting with no new byte accepted: have_byte=0, so chain_shift_en=0 (stall) until a byte arrives. The chain does not advance during a stall.
- Terminal shift (remaining==1): next state DONE.
  - done=1, busy=0, have_byte=0, cfg_ready=0.
  - Unused low bits of the final partial byte are discarded and never reach ccff_head.
- busy = (state==LOAD).
- cfg_valid while not ready is ignored; no data is consumed.
- Reset mid-LOAD aborts the session immediately. A new start is required, and the chain must be fully reloaded.
- Latency: first bit appears on ccff_head, with chain_shift_en=1, the cycle after the byte is accepted. done asserts the cycle after the CHAIN_LEN-th shift.

Test Plan:
- CHAIN_LEN=12; start; bytes 0xA5, 0x3C with valid held high -> exactly 12 consecutive shift cycles, head sequence 1,0,1,0,0,1,0,1,0,0,1,1. Second byte accepted on the cycle bit 7 of 0xA5 shifts. Then done=1, busy=0; low 4 bits of 0x3C are never shifted.
- Same load with cfg_valid dropped for 3 cycles after the first byte -> chain_shift_en=0 for exactly those stall cycles. Total shift count is still 12 and the head sequence is unchanged.
- Chain model preloaded with 0xFFF, load 0x00, 0x00 -> tail_ones=12 at done. Reload the same chain -> tail_ones=0.
- start asserted during LOAD -> no effect: remaining and tail_ones are not cleared, and the session completes normally.
- prog_reset_n low after 5 shifts -> all outputs 0 asynchronously. After release, start plus a full 12-bit load produces 12 shifts and done.
- CHAIN_LEN=8 (byte-aligned) -> one byte accepted, cfg_ready never re-asserts in the session, 8 shifts, done the following cycle.
